// File: rtl/prog3_mult_ctrl.sv
// Sequencer for program 3: reads signed 16-bit operand pairs from byte memory,
// multiplies them with a 16-step shift-add loop and writes 32-bit products back MSB first.
module prog3_mult_ctrl #(
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64,
  parameter int N_PAIRS  = 16,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int JW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_AH, S_RD_AL, S_RD_BH, S_RD_BL, S_MUL,
    S_WR0, S_WR1, S_WR2, S_WR3, S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic          armed_reg, armed_next;
  logic [JW-1:0] j_reg, j_next;
  logic [3:0]    i_reg, i_next;
  logic [15:0]   a_reg, a_next;
  logic [15:0]   b_reg, b_next;
  logic [31:0]   acc_reg, acc_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [7:0]    wd_reg, wd_next;
  logic          wr_en;

  logic [AW-1:0] pair_off;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [31:0]   term;

  assign pair_off = AW'({j_reg, 2'b00});
  assign src_addr = AW'(SRC_BASE) + pair_off;
  assign dst_addr = AW'(DST_BASE) + pair_off;
  assign term     = {{16{a_reg[15]}}, a_reg} << i_reg;

  always_comb begin
    state_next = state_reg;
    armed_next = armed_reg;
    j_next     = j_reg;
    i_next     = i_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    addr_next  = addr_reg;
    wd_next    = wd_reg;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          armed_next = 1'b0;
          j_next     = '0;
          state_next = S_RD_AH;
        end
      end
      S_RD_AH: begin
        busy       = 1'b1;
        addr_next  = src_addr;
        a_next     = {mem_rd_data, a_reg[7:0]};
        state_next = S_RD_AL;
      end
      S_RD_AL: begin
        busy       = 1'b1;
        addr_next  = src_addr + AW'(1);
        a_next     = {a_reg[15:8], mem_rd_data};
        state_next = S_RD_BH;
      end
      S_RD_BH: begin
        busy       = 1'b1;
        addr_next  = src_addr + AW'(2);
        b_next     = {mem_rd_data, b_reg[7:0]};
        state_next = S_RD_BL;
      end
      S_RD_BL: begin
        busy       = 1'b1;
        addr_next  = src_addr + AW'(3);
        b_next     = {b_reg[15:8], mem_rd_data};
        acc_next   = '0;
        i_next     = '0;
        state_next = S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        // Bit 15 of B carries negative weight in two's complement.
        if (b_reg[i_reg]) begin
          acc_next = (i_reg == 4'd15) ? acc_reg - term : acc_reg + term;
        end
        i_next = i_reg + 4'd1;
        if (i_reg == 4'd15) state_next = S_WR0;
      end
      S_WR0: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        addr_next  = dst_addr;
        wd_next    = acc_reg[31:24];
        state_next = S_WR1;
      end
      S_WR1: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        addr_next  = dst_addr + AW'(1);
        wd_next    = acc_reg[23:16];
        state_next = S_WR2;
      end
      S_WR2: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        addr_next  = dst_addr + AW'(2);
        wd_next    = acc_reg[15:8];
        state_next = S_WR3;
      end
      S_WR3: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        addr_next  = dst_addr + AW'(3);
        wd_next    = acc_reg[7:0];
        if (j_reg == JW'(N_PAIRS - 1)) begin
          state_next = S_DONE;
        end else begin
          j_next     = j_reg + JW'(1);
          state_next = S_RD_AH;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          armed_next = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address/data are the values chosen this cycle; the registers only hold them between accesses.
  assign mem_addr    = addr_next;
  assign mem_wr_data = wd_next;
  assign mem_wr_en   = wr_en & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      armed_reg <= 1'b0;
      j_reg     <= '0;
      i_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      addr_reg  <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      armed_reg <= armed_next;
      j_reg     <= j_next;
      i_reg     <= i_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      addr_reg  <= addr_next;
      wd_reg    <= wd_next;
    end
  end

endmodule

// File: tb/tb_prog3_mult_ctrl.sv
// Bench for prog3_mult_ctrl: byte memory model, operand/product vector table,
// handshake, reset-abort and mid-run start corner sequences.
module tb_prog3_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = '0;
  logic [7:0] tb_wd = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tr_addr [512];
  logic       tr_we   [512];
  logic [7:0] tr_wd   [512];
  int         tcnt    = 0;
  int         stray   = 0;
  logic       prev_busy = 1'b0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t tbl [16];

  prog3_mult_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  // Per-run trace of what the DUT drives on every busy cycle.
  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) tcnt = 0;
      if (tcnt < 512) begin
        tr_addr[tcnt] = mem_addr;
        tr_we[tcnt]   = mem_wr_en;
        tr_wd[tcnt]   = mem_wr_data;
        tcnt++;
      end
    end
    if (mem_wr_en && !busy) stray++;
    prev_busy = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic poke(input int addr, input logic [7:0] d);
    tb_we = 1'b1;
    tb_wa = 8'(addr);
    tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  function automatic logic [31:0] prod_at(input int j);
    return {mem[64 + 4*j], mem[65 + 4*j], mem[66 + 4*j], mem[67 + 4*j]};
  endfunction

  task automatic load_table(input logic use_table);
    logic [15:0] a;
    logic [15:0] b;
    for (int j = 0; j < 16; j++) begin
      a = use_table ? tbl[j].a : 16'd3;
      b = use_table ? tbl[j].b : 16'd5;
      poke(4*j,     a[15:8]);
      poke(4*j + 1, a[7:0]);
      poke(4*j + 2, b[15:8]);
      poke(4*j + 3, b[7:0]);
    end
    for (int k = 64; k < 128; k++) poke(k, 8'hAA);
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    if (!done) check({tag, "_done_timeout"}, 32'(done), 32'd1);
    check({tag, "_cycles"}, 32'(tcnt), 32'd384);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_wren_in_done"}, 32'(mem_wr_en), 32'd0);
  endtask

  task automatic check_products(input string tag, input logic use_table);
    logic [31:0] exp;
    for (int j = 0; j < 16; j++) begin
      exp = use_table ? tbl[j].p : 32'h0000000F;
      check($sformatf("%s_prod%0d", tag, j), prod_at(j), exp);
    end
  endtask

  initial begin
    int bad;
    logic [31:0] p3;

    tbl[0]  = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[1]  = '{16'h8000, 16'h7FFF, 32'hC0008000};
    tbl[2]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[3]  = '{16'h0000, 16'hCFC7, 32'h00000000};
    tbl[4]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[5]  = '{16'h0003, 16'h0005, 32'h0000000F};
    tbl[6]  = '{16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    tbl[7]  = '{16'h0001, 16'h8000, 32'hFFFF8000};
    tbl[8]  = '{16'h0100, 16'h0100, 32'h00010000};
    tbl[9]  = '{16'hFFFE, 16'h8000, 32'h00010000};
    tbl[10] = '{16'h0064, 16'hFF9C, 32'hFFFFD8F0};
    tbl[11] = '{16'h3039, 16'h0000, 32'h00000000};
    tbl[12] = '{16'h7FFF, 16'hFFFF, 32'hFFFF8001};
    tbl[13] = '{16'h8000, 16'h0001, 32'hFFFF8000};
    tbl[14] = '{16'h1234, 16'h0010, 32'h00012340};
    tbl[15] = '{16'h03E8, 16'h03E8, 32'h000F4240};

    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) poke(k, 8'h00);
    tick();
    reset = 1'b0;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wren", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wr_data), 32'd0);

    // Run 1: all pairs 3*5, plus full address/strobe trace.
    load_table(1'b0);
    check("idle_no_launch", 32'(busy), 32'd0);
    launch();
    wait_done("run1");
    check_products("run1", 1'b0);
    check("tr_p0_rd0", 32'(tr_addr[0]), 32'd0);
    check("tr_p0_rd3", 32'(tr_addr[3]), 32'd3);
    check("tr_p0_wr0_addr", 32'(tr_addr[20]), 32'd64);
    check("tr_p0_wr0_data", 32'(tr_wd[20]), 32'h00);
    check("tr_p0_wr3_addr", 32'(tr_addr[23]), 32'd67);
    check("tr_p0_wr3_data", 32'(tr_wd[23]), 32'h0F);
    check("tr_p15_wr0_addr", 32'(tr_addr[380]), 32'd124);
    check("tr_p15_wr3_addr", 32'(tr_addr[383]), 32'd127);
    bad = 0;
    for (int c = 0; c < 384; c++) begin
      if (tr_we[c] !== ((c % 24) >= 20)) bad++;
      if ((c % 24) < 4 && tr_addr[c] !== 8'(4*(c/24) + c%24)) bad++;
      if ((c % 24) >= 20 && tr_addr[c] !== 8'(64 + 4*(c/24) + c%24 - 20)) bad++;
    end
    check("trace_pattern_errors", 32'(bad), 32'd0);

    // Handshake: done holds, start=1 clears it, start=0 relaunches with new operands.
    load_table(1'b1);
    check("done_held", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    check("done_cleared", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    start = 1'b0;
    wait_done("run2");
    check_products("run2", 1'b1);

    // Reset at cycle 100 of a run.
    for (int k = 64; k < 128; k++) poke(k, 8'hAA);
    launch();
    bad = 0;
    while (!(busy && tcnt == 100) && bad < 1000) begin
      tick();
      bad++;
    end
    check("reach_cycle100", 32'(tcnt), 32'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wren", 32'(mem_wr_en), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_wdata", 32'(mem_wr_data), 32'd0);
    check("abort_kept_p3", prod_at(3), tbl[3].p);
    check("abort_p4_untouched", prod_at(4), 32'hAAAAAAAA);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (busy || done) bad++;
    end
    check("no_launch_after_reset", 32'(bad), 32'd0);

    // Full run with a start pulse in the middle of pair 0's multiply.
    for (int k = 64; k < 128; k++) poke(k, 8'h55);
    launch();
    while (!(busy && tcnt >= 10)) tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done("run3");
    check_products("run3", 1'b1);
    p3 = 32'(stray);
    check("stray_writes", p3, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x%08h, expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
